// File: rtl/ula_multiciclo_if.sv
// Start/done handshake bundle between the register-file controller and the multi-cycle ALU.
// The controller drives the request side; the ALU returns result and flags.
interface ula_multiciclo_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             zero;
    logic             carry;

    modport master (
        output start, op, a, b,
        input  result, done, busy, zero, carry
    );

    modport slave (
        input  start, op, a, b,
        output result, done, busy, zero, carry
    );
endinterface

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith, shift-add MUL, restoring DIV.
// Optional divider: define ULA_DIV_EN; otherwise op 111 flags an illegal op.
module ula_multiciclo #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 3
) (
    input logic            clk,
    input logic            rst_n,
    ula_multiciclo_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t               r_state;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [ITER_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic [2*WIDTH-1:0]   r_mc;
    logic [WIDTH-1:0]     r_result;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_zero;
    logic                 r_carry;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_dif;
    logic [WIDTH:0]       w_shl;
    logic [2*WIDTH-1:0]   w_pnext;
    logic [WIDTH-1:0]     w_res;
    logic                 w_cy;
    logic                 w_multi;
    logic                 w_last;
`ifdef ULA_DIV_EN
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_rnext;
    logic [WIDTH-1:0]     w_qnext;
`endif

    always_comb begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_dif   = {1'b0, r_a} - {1'b0, r_b};
        // bit WIDTH of the widened shift holds the last bit pushed out
        w_shl   = {1'b0, r_a} << r_b[ITER_W-1:0];
        w_pnext = r_p + (r_b[0] ? r_mc : '0);
        w_last  = (r_cnt == ITER_W'(WIDTH - 1));
`ifdef ULA_DIV_EN
        w_shift = {r_rem, r_a[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_b};
        w_rnext = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_qnext = {r_a[WIDTH-2:0], ~w_trial[WIDTH]};
        w_multi = (r_op == OP_MUL) || (r_op == OP_DIV);
`else
        w_multi = (r_op == OP_MUL);
`endif
        w_res = '0;
        w_cy  = 1'b0;
        unique case (r_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_cy  = w_dif[WIDTH];
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_NOT: w_res = ~r_a;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_cy  = w_shl[WIDTH];
            end
            OP_MUL: begin
                w_res = w_pnext[WIDTH-1:0];
                w_cy  = |w_pnext[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
`ifdef ULA_DIV_EN
                w_res = w_qnext;
                w_cy  = (r_b == '0);
`else
                w_res = '0;
                w_cy  = 1'b1;
`endif
            end
            default: begin
                w_res = '0;
                w_cy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_mc     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
`ifdef ULA_DIV_EN
            r_rem    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_cnt   <= '0;
                        r_p     <= '0;
                        r_mc    <= {{WIDTH{1'b0}}, bus.a};
`ifdef ULA_DIV_EN
                        r_rem   <= '0;
`endif
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_MUL) begin
                        r_p  <= w_pnext;
                        r_mc <= r_mc << 1;
                        r_b  <= r_b >> 1;
                    end
`ifdef ULA_DIV_EN
                    if (r_op == OP_DIV) begin
                        r_rem <= w_rnext;
                        r_a   <= w_qnext;
                    end
`endif
                    if (!w_multi || w_last) begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_carry  <= w_cy;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.zero   = r_zero;
    assign bus.carry  = r_carry;
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Multi-cycle ALU sitting directly downstream of the 4x8-bit register file. It consumes read ports a/b, executes one operation per start request, and returns an 8-bit result plus flags for write-back into write_data.
Single-cycle logic/arith ops and iterative shift-add multiply / restoring divide share one start/done handshake. The controller pulses start and waits for done before asserting the register-file write_enable.

Parameters:
WIDTH, 8, operand/result width; must match the register-file data width
ITER_W, 3, iteration counter width; 2**ITER_W must equal WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  3  operation select, latched with start
a  input  WIDTH  operand A (register-file port a), latched with start
b  input  WIDTH  operand B (register-file port b), latched with start
result  output  WIDTH  registered result, held until next done
done  output  1  one-cycle pulse, result/flags valid
busy  output  1  high from accepting edge until the done edge
zero  output  1  result == 0, updated with done
carry  output  1  carry/borrow/overflow/error flag, updated with done

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low forces state IDLE, result=0, done=0, busy=0, zero=0, carry=0, internal counters/operand regs=0.
- States: IDLE, EXEC, DONE.
  - IDLE: start=1 at edge N latches op/a/b, clears counter, sets busy, goes to EXEC.
  - EXEC (single-cycle op): at edge N+1, compute, register result/flags, pulse done, clear busy, go to IDLE.
  - EXEC (mul/div): one iteration per edge. Counter runs 0..WIDTH-1. At edge N+WIDTH, register result/flags, pulse done, clear busy, go to IDLE.
  - DONE: transient encoding only; done is high for exactly one cycle after the finishing edge.
- start while busy=1: ignored; latched operands are unchanged. start sampled in the cycle done=1 is accepted, giving back-to-back ops.
- Ops; all widths are WIDTH with modulo-2**WIDTH wrap:
  - 000 ADD: result=a+b; carry=carry-out.
  - 001 SUB: result=a-b; carry=borrow (a<b).
  - 010 AND; 011 OR; 100 NOT a. For all three, carry=0.
  - 101 SHL: result=a<<b[2:0]; carry=last bit shifted out (0 when shift=0).
  - 110 MUL: shift-add, low WIDTH bits; carry=1 if the high WIDTH bits are nonzero.
  - 111 DIV: restoring, quotient a/b. When b=0: result=all ones, carry=1, still takes WIDTH cycles.
- zero is computed from the final registered result for every op.
- Reset mid-operation aborts immediately; no done pulse is produced for the aborted op.
- Inputs a/b/op may change freely after the accepting edge without affecting the running op.

Optional Feature:
- Macro: ULA_DIV_EN.
- Defined: op 111 performs the restoring divide as above.
- Undefined: divider hardware is not built. op 111 completes as a single-cycle op at edge N+1 with result=0, zero=1, carry=1 (illegal-op indication).

Test Plan:
1. Reset then ADD a=0xF5 b=0x53, start at edge N -> done at N+1, result=0x48, carry=1, zero=0, busy high for one cycle.
2. MUL a=0x0D b=0x0B -> busy for 8 cycles, done at N+8, result=0x8F, carry=0; then MUL a=0x20 b=0x10 -> result=0x00, zero=1, carry=1.
3. With ULA_DIV_EN: DIV a=0xF5 b=0x53 -> done at N+8, result=0x02, carry=0; DIV a=0x40 b=0x00 -> result=0xFF, carry=1. Without the macro: DIV -> done at N+1, result=0x00, zero=1, carry=1.
4. During MUL a=0x0D b=0x0B, pulse start with op=000, a=0x01, b=0x01 at N+3 -> ignored; the single done at N+8 shows 0x8F.
5. Assert start in the done cycle with SUB a=0x10 b=0x20 -> accepted; next done one cycle later, result=0xF0, carry=1.
6. Drop rst_n at N+4 of a MUL -> busy/done/result/flags return to 0 asynchronously; no done pulse follows; a new ADD after release completes normally.
